// File: rtl/spi_lcd_target.sv
// spi_lcd_target
// Receive end of the LCD SPI link (mode 0, MSB first). The SPI pins are
// oversampled in the system clock domain. Each completed byte is tagged
// with the LCD DC flag and pushed into a small FIFO that has a
// valid/ready output.
//
// Ports
//   clk_sys_i          system clock (the only clock)
//   rst_sys_i          synchronous active-high reset
//   spi_sck_i          SPI clock, asynchronous
//   spi_cs_ni          chip select, active-low, asynchronous
//   spi_copi_i         serial data, asynchronous
//   spi_dc_i           LCD data/command flag, asynchronous
//   rx_valid_o         FIFO head holds a byte
//   rx_ready_i         consumer takes the head byte
//   rx_data_o          head byte
//   rx_dc_o            DC captured with the head byte
//   overflow_o         sticky: a completed byte was dropped (FIFO full)
//   partial_o          sticky: CS released with 1-7 bits received
//   clear_i            clears overflow_o and partial_o
//   byte_count_o       bytes written into the FIFO, wrapping
module spi_lcd_target #(
    parameter int FifoDepth  = 4,
    parameter int CountWidth = 16
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_i,
    input  logic                  spi_sck_i,
    input  logic                  spi_cs_ni,
    input  logic                  spi_copi_i,
    input  logic                  spi_dc_i,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [7:0]            rx_data_o,
    output logic                  rx_dc_o,
    output logic                  overflow_o,
    output logic                  partial_o,
    input  logic                  clear_i,
    output logic [CountWidth-1:0] byte_count_o
);

    localparam int AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [AW:0]           FULL_C    = (AW+1)'(FifoDepth);
    localparam logic [AW:0]           CNT_ONE_C = (AW+1)'(1);
    localparam logic [AW-1:0]         PTR_ONE_C = AW'(1);
    localparam logic [CountWidth-1:0] BYTE_ONE_C = CountWidth'(1);

    logic sck_s1_r, sck_s2_r, sck_s3_r;
    logic cs_n_s1_r, cs_n_s2_r;
    logic copi_s1_r, copi_s2_r;
    logic dc_s1_r, dc_s2_r;

    logic [2:0] bit_cnt_r;
    logic [6:0] shift_r;

    logic [7:0]    mem_data_r [FifoDepth];
    logic          mem_dc_r   [FifoDepth];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r;
    logic [7:0]    hold_data_r;
    logic          hold_dc_r;

    logic                  overflow_r, partial_r;
    logic [CountWidth-1:0] byte_count_r;

    logic       rise_s, sample_s, byte_done_s, abort_s;
    logic       empty_s, pop_s, wr_ok_s, drop_s;
    logic [7:0] new_byte_s;

    // Two-flop synchronisers, plus an SCK history flop for edge detection
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            sck_s1_r  <= 1'b0;
            sck_s2_r  <= 1'b0;
            sck_s3_r  <= 1'b0;
            cs_n_s1_r <= 1'b1;
            cs_n_s2_r <= 1'b1;
            copi_s1_r <= 1'b0;
            copi_s2_r <= 1'b0;
            dc_s1_r   <= 1'b0;
            dc_s2_r   <= 1'b0;
        end else begin
            sck_s1_r  <= spi_sck_i;
            sck_s2_r  <= sck_s1_r;
            sck_s3_r  <= sck_s2_r;
            cs_n_s1_r <= spi_cs_ni;
            cs_n_s2_r <= cs_n_s1_r;
            copi_s1_r <= spi_copi_i;
            copi_s2_r <= copi_s1_r;
            dc_s1_r   <= spi_dc_i;
            dc_s2_r   <= dc_s1_r;
        end
    end

    // Edge detection, byte completion and FIFO push/pop decisions
    always_comb begin
        rise_s      = sck_s2_r & ~sck_s3_r;
        sample_s    = rise_s & ~cs_n_s2_r;
        byte_done_s = sample_s & (bit_cnt_r == 3'd7);
        abort_s     = cs_n_s2_r & (bit_cnt_r != 3'd0);
        new_byte_s  = {shift_r, copi_s2_r};
        empty_s     = (count_r == {(AW+1){1'b0}});
        pop_s       = ~empty_s & rx_ready_i;
        // A full FIFO still takes the byte if its head leaves on this edge
        wr_ok_s     = byte_done_s & ((count_r != FULL_C) | pop_s);
        drop_s      = byte_done_s & ~wr_ok_s;
    end

    // Deserialiser: bit counter and shift register
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 7'd0;
        end else if (abort_s) begin
            bit_cnt_r <= 3'd0;
        end else if (sample_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            shift_r   <= {shift_r[5:0], copi_s2_r};
        end
    end

    // Receive FIFO storage, pointers and occupancy
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {(AW+1){1'b0}};
            hold_data_r <= 8'd0;
            hold_dc_r   <= 1'b0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem_data_r[i] <= 8'd0;
                mem_dc_r[i]   <= 1'b0;
            end
        end else begin
            if (wr_ok_s) begin
                mem_data_r[wr_ptr_r] <= new_byte_s;
                mem_dc_r[wr_ptr_r]   <= dc_s2_r;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                // Keep the departing byte so the output holds once empty
                hold_data_r <= mem_data_r[rd_ptr_r];
                hold_dc_r   <= mem_dc_r[rd_ptr_r];
                rd_ptr_r    <= rd_ptr_r + PTR_ONE_C;
            end
            case ({wr_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags (set beats clear) and accepted-byte counter
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            overflow_r   <= 1'b0;
            partial_r    <= 1'b0;
            byte_count_r <= {CountWidth{1'b0}};
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_i) begin
                overflow_r <= 1'b0;
            end
            if (abort_s) begin
                partial_r <= 1'b1;
            end else if (clear_i) begin
                partial_r <= 1'b0;
            end
            if (wr_ok_s) begin
                byte_count_r <= byte_count_r + BYTE_ONE_C;
            end
        end
    end

    // Output mapping: head entry while valid, last popped byte otherwise
    always_comb begin
        rx_valid_o   = ~empty_s;
        rx_data_o    = hold_data_r;
        rx_dc_o      = hold_dc_r;
        if (!empty_s) begin
            rx_data_o = mem_data_r[rd_ptr_r];
            rx_dc_o   = mem_dc_r[rd_ptr_r];
        end else begin
            rx_data_o = hold_data_r;
            rx_dc_o   = hold_dc_r;
        end
        overflow_o   = overflow_r;
        partial_o    = partial_r;
        byte_count_o = byte_count_r;
    end

endmodule

// File: tb/tb_spi_lcd_target.sv
module tb_spi_lcd_target;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0, cs_n = 1'b1, copi = 1'b0, dc = 1'b0;
    logic        rdy = 1'b0, clr = 1'b0;
    logic        rx_valid, rx_dc, overflow, partial;
    logic [7:0]  rx_data;
    logic [15:0] byte_count;

    spi_lcd_target #(.FifoDepth(DEPTH), .CountWidth(16)) dut (
        .clk_sys_i(clk), .rst_sys_i(rst),
        .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_copi_i(copi), .spi_dc_i(dc),
        .rx_valid_o(rx_valid), .rx_ready_i(rdy), .rx_data_o(rx_data), .rx_dc_o(rx_dc),
        .overflow_o(overflow), .partial_o(partial), .clear_i(clr),
        .byte_count_o(byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int last8_edge = -100;
    int rdy_mode = 0;    // 0 low, 1 high, 2 random, 3 single pulse on the completion edge
    bit lat_armed = 1'b0;

    // Reference model: expected bytes {dc, data} in arrival order
    logic [8:0] exp_q[$];
    int         exp_count = 0;
    bit         exp_ovf = 1'b0;
    logic [8:0] mon_e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A completed byte is accepted if the FIFO has room or its head leaves on the same edge
    task automatic model_complete(input logic [7:0] b, input logic d, input bit pop_same);
        if (exp_q.size() < DEPTH || pop_same) begin
            exp_q.push_back({d, b});
            exp_count = (exp_count + 1) % 65536;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    // Mode-0 frame: SCK period 8 clocks, data set up while SCK is low
    task automatic send(input logic [7:0] b, input logic d, input int nbits,
                        input bit release_cs, input bit pop_same);
        cs_n = 1'b0;
        dc   = d;
        wclk(4);
        for (int i = 0; i < nbits; i++) begin
            copi = b[7-i];
            wclk(4);
            sck = 1'b1;
            if (i == 7) begin
                last8_edge = edge_cnt;
                model_complete(b, d, pop_same);
            end
            wclk(4);
            sck = 1'b0;
        end
        if (release_cs) begin
            wclk(4);
            cs_n = 1'b1;
            wclk(6);
        end
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0) break;
            wclk(1);
        end
        chk("drain_empty", exp_q.size(), 0);
        wclk(3);
        chk("drain_valid_low", 32'(rx_valid), 0);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        wclk(1);
        clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(rx_valid), 0);
        chk({tag, "_data"}, 32'(rx_data), 0);
        chk({tag, "_dc"}, 32'(rx_dc), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_partial"}, 32'(partial), 0);
        chk({tag, "_count"}, 32'(byte_count), 0);
    endtask

    // Consumer ready driver
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = 1'($urandom_range(0, 1));
            3:       rdy = (edge_cnt == last8_edge + 2);
            default: rdy = 1'b0;
        endcase
    end

    // Monitor: latency check and scoreboard compare on each pop
    always @(negedge clk) begin
        if (lat_armed && rx_valid === 1'b1) begin
            chk("latency_edges", edge_cnt - last8_edge, 3);
            lat_armed = 1'b0;
        end
        if (rx_valid === 1'b1 && rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got data 0x%02h dc %0d expected no byte", rx_data, rx_dc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(mon_e[7:0]));
                chk("rx_dc", 32'(rx_dc), 32'(mon_e[8]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        wclk(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wclk(2);

        // SCK toggling with CS high is ignored
        for (int i = 0; i < 8; i++) begin
            copi = 1'($urandom_range(0, 1));
            sck = 1'b1; wclk(4);
            sck = 1'b0; wclk(4);
        end
        wclk(6);
        chk("cs_high_count", 32'(byte_count), 0);
        chk("cs_high_partial", 32'(partial), 0);
        chk("cs_high_valid", 32'(rx_valid), 0);

        // Single byte, latency from the 8th SCK high
        rdy_mode = 1;
        lat_armed = 1'b1;
        send(8'hA5, 1'b1, 8, 1'b1, 1'b0);
        wclk(10);
        chk("latency_seen", 32'(lat_armed), 0);
        chk("single_count", 32'(byte_count), 32'(exp_count));
        chk("single_consumed", exp_q.size(), 0);

        // Overflow: five bytes into a four-entry FIFO with no consumer
        rdy_mode = 0;
        wclk(2);
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b0, 8, 1'b1, 1'b0);
        wclk(5);
        chk("ovf_set", 32'(overflow), 32'(exp_ovf));
        chk("ovf_count", 32'(byte_count), 32'(exp_count));
        chk("ovf_valid", 32'(rx_valid), 1);
        drain();
        pulse_clear();
        exp_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'(exp_ovf));

        // Full FIFO, fifth byte lands on the same edge as a pop
        rdy_mode = 0;
        for (int v = 1; v <= 4; v++) send(8'(v), 1'($urandom_range(0, 1)), 8, 1'b1, 1'b0);
        rdy_mode = 3;
        send(8'h05, 1'b1, 8, 1'b1, 1'b1);
        rdy_mode = 0;
        wclk(2);
        chk("popsame_ovf", 32'(overflow), 0);
        chk("popsame_left", exp_q.size(), 4);
        chk("popsame_count", 32'(byte_count), 32'(exp_count));
        drain();

        // Aborted partial byte, then a clean byte with no misalignment
        chk("partial_pre", 32'(partial), 0);
        send(8'hE0, 1'b0, 3, 1'b1, 1'b0);
        chk("partial_set", 32'(partial), 1);
        rdy_mode = 1;
        send(8'h3C, 1'b1, 8, 1'b1, 1'b0);
        drain();
        chk("partial_count", 32'(byte_count), 32'(exp_count));
        pulse_clear();
        chk("partial_cleared", 32'(partial), 0);

        // Random bytes with a random consumer
        rdy_mode = 2;
        for (int i = 0; i < 12; i++)
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8, 1'b1, 1'b0);
        drain();
        chk("random_count", 32'(byte_count), 32'(exp_count));
        chk("random_ovf", 32'(overflow), 0);

        // Reset in the middle of a byte
        rdy_mode = 1;
        send(8'h5A, 1'b1, 5, 1'b0, 1'b0);
        rst = 1'b1;
        wclk(2);
        check_reset_outputs("midreset");
        cs_n = 1'b1;
        copi = 1'b0;
        dc = 1'b0;
        wclk(2);
        rst = 1'b0;
        exp_q.delete();
        exp_count = 0;
        exp_ovf = 1'b0;
        wclk(6);
        chk("midreset_partial", 32'(partial), 0);
        send(8'hFF, 1'b0, 8, 1'b1, 1'b0);
        drain();
        chk("midreset_count", 32'(byte_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
